// File: rtl/voice_allocator.sv
// Polyphonic voice allocator. Maps key events onto oscillator slots and runs a
// per-voice attack/sustain/release envelope on each slot's attenuation shift.

module voice_allocator_voice #(
   parameter int ATTACK_START = 8,
   parameter int RELEASE_DIV  = 4
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        i_tick,
   input  logic        i_load,
   input  logic [5:0]  i_key,
   input  logic [11:0] i_freq,
   input  logic        i_rel,
   output logic [5:0]  o_key,
   output logic [11:0] o_freq,
   output logic [3:0]  o_vol,
   output logic        o_busy,
   output logic        o_stop,
   output logic        o_held
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ATTACK  = 2'd1;
   localparam logic [1:0] ST_SUSTAIN = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;
   localparam logic [3:0] START_VOL  = 4'(ATTACK_START);
   localparam logic [3:0] DIV_LAST   = 4'(RELEASE_DIV - 1);

   logic [1:0]  r_state;
   logic [5:0]  r_key;
   logic [11:0] r_freq;
   logic [3:0]  r_vol;
   logic [3:0]  r_cnt;

   // A key event on this voice takes precedence over the envelope tick.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_key   <= '0;
         r_freq  <= '0;
         r_vol   <= 4'd15;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_state <= (ATTACK_START == 0) ? ST_SUSTAIN : ST_ATTACK;
         r_key   <= i_key;
         r_freq  <= i_freq;
         r_vol   <= START_VOL;
         r_cnt   <= '0;
      end else if (i_rel) begin
         r_state <= ST_RELEASE;
         r_cnt   <= '0;
      end else if (i_tick) begin
         case (r_state)
            ST_ATTACK: begin
               if (r_vol <= 4'd1) begin
                  r_vol   <= 4'd0;
                  r_state <= ST_SUSTAIN;
               end else begin
                  r_vol <= r_vol - 4'd1;
               end
            end
            ST_RELEASE: begin
               if (r_cnt == DIV_LAST) begin
                  r_cnt <= '0;
                  if (r_vol >= 4'd14) begin
                     r_vol   <= 4'd15;
                     r_state <= ST_IDLE;
                  end else begin
                     r_vol <= r_vol + 4'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_key  = r_key;
   assign o_freq = r_freq;
   assign o_vol  = r_vol;
   assign o_busy = (r_state != ST_IDLE);
   assign o_stop = (r_state == ST_IDLE) || (r_state == ST_RELEASE);
   assign o_held = (r_state == ST_ATTACK) || (r_state == ST_SUSTAIN);
endmodule

module voice_allocator #(
   parameter int NUM_NOTES    = 6,
   parameter int ATTACK_START = 8,
   parameter int RELEASE_DIV  = 4
) (
   input  logic                        CLOCK_50,
   input  logic                        reset,
   input  logic                        env_tick,
   input  logic                        key_down,
   input  logic [5:0]                  down_code,
   input  logic [11:0]                 down_freq,
   input  logic                        key_up,
   input  logic [5:0]                  up_code,
   output logic [NUM_NOTES-1:0][11:0]  freq,
   output logic [NUM_NOTES-1:0]        stop,
   output logic [NUM_NOTES-1:0][3:0]   volume,
   output logic [NUM_NOTES-1:0]        busy,
   output logic                        stolen
);
   localparam int SW = $clog2(NUM_NOTES);

   logic [NUM_NOTES-1:0][5:0] w_key;
   logic [NUM_NOTES-1:0]      w_held;
   logic [NUM_NOTES-1:0]      w_dn_hit;
   logic [NUM_NOTES-1:0]      w_up_hit;
   logic [NUM_NOTES-1:0]      w_load;
   logic [NUM_NOTES-1:0]      w_rel;
   logic [SW-1:0]             w_idle_idx;
   logic                      w_any_idle;
   logic                      w_any_hit;
   logic                      w_steal;
   logic                      w_same;
   logic [SW-1:0]             r_steal_ptr;
   logic                      r_stolen;

   assign w_same    = key_down && (down_code == up_code);
   assign w_any_hit = |w_dn_hit;
   assign w_any_idle = ~&busy;
   assign w_steal   = key_down && !w_any_hit && !w_any_idle;

   // Lowest-index idle voice wins allocation.
   always_comb begin
      w_idle_idx = '0;
      for (int i = NUM_NOTES - 1; i >= 0; i--) begin
         if (!busy[i]) w_idle_idx = SW'(i);
      end
   end

   // Retrigger before allocation keeps key ids unique across active voices.
   always_comb begin
      w_load = '0;
      if (key_down) begin
         if (w_any_hit)       w_load = w_dn_hit;
         else if (w_any_idle) w_load[w_idle_idx] = 1'b1;
         else                 w_load[r_steal_ptr] = 1'b1;
      end
   end

   generate
      for (genvar g = 0; g < NUM_NOTES; g++) begin : g_voice
         assign w_dn_hit[g] = busy[g] && (w_key[g] == down_code);
         assign w_up_hit[g] = w_held[g] && (w_key[g] == up_code);
         // A release aimed at a voice being stolen in the same cycle is dropped.
         assign w_rel[g]    = key_up && !w_same && w_up_hit[g] && !w_load[g];

         voice_allocator_voice #(
            .ATTACK_START (ATTACK_START),
            .RELEASE_DIV  (RELEASE_DIV)
         ) u_voice (
            .CLOCK_50 (CLOCK_50),
            .reset    (reset),
            .i_tick   (env_tick),
            .i_load   (w_load[g]),
            .i_key    (down_code),
            .i_freq   (down_freq),
            .i_rel    (w_rel[g]),
            .o_key    (w_key[g]),
            .o_freq   (freq[g]),
            .o_vol    (volume[g]),
            .o_busy   (busy[g]),
            .o_stop   (stop[g]),
            .o_held   (w_held[g])
         );
      end
   endgenerate

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_steal_ptr <= '0;
         r_stolen    <= 1'b0;
      end else begin
         r_stolen <= w_steal;
         if (w_steal) begin
            if (r_steal_ptr == SW'(NUM_NOTES - 1)) r_steal_ptr <= '0;
            else                                    r_steal_ptr <= r_steal_ptr + 1'b1;
         end
      end
   end

   assign stolen = r_stolen;
endmodule
